vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//  Pixel-timing generator feeding Controlador_VGA: divides the 50 MHz system clock into the
//  25 MHz pixel tick and runs horizontal/vertical counters for 640x480@60Hz. Produces
//  hsync/vsync, video_on and the current pixel coordinates, which the controller uses to
//  gate rgbswitches onto rgbtext. Pure timing source; carries no colour data.
// PARAMETERS
//  DIV        2    system clocks per pixel (>=1); 50 MHz / 2 = 25 MHz pixel rate
//  H_DISPLAY  640  visible pixels per line
//  H_FRONT    16   horizontal front porch, pixels
//  H_SYNC     96   hsync pulse width, pixels
//  H_BACK     48   horizontal back porch, pixels (H_TOTAL = 800)
//  V_DISPLAY  480  visible lines per frame
//  V_FRONT    10   vertical front porch, lines
//  V_SYNC     2    vsync pulse width, lines
//  V_BACK     33   vertical back porch, lines (V_TOTAL = 525)
//  SYNC_POL   0    active level of hsync/vsync (0 = active-low, the VGA 640x480 standard)
// PORTS
//  clk          in   1   system clock, 50 MHz
//  reset        in   1   asynchronous, active-low reset
//  p_tick       out  1   one-clk pulse per pixel period; counters advance on it
//  pixel_x      out  10  horizontal count, 0..H_TOTAL-1
//  pixel_y      out  10  vertical count, 0..V_TOTAL-1
//  video_on     out  1   1 when pixel_x<H_DISPLAY && pixel_y<V_DISPLAY
//  hsync        out  1   horizontal sync, SYNC_POL when asserted
//  vsync        out  1   vertical sync, SYNC_POL when asserted
//  frame_start  out  1   one-clk pulse in the cycle the counters enter (0,0)
// BEHAVIOUR
//  - Reset (reset=0, async): div count=0, pixel_x=0, pixel_y=0, p_tick=0, frame_start=0,
//    hsync=vsync=~SYNC_POL, video_on=1 (matches position 0,0). Release is synchronous to clk.
//  - Divider: count 0..DIV-1, wraps. p_tick is registered, high exactly one clk per DIV
//    clks, asserted in the cycle count==DIV-1. DIV=1 -> p_tick held high.
//  - On each clk with p_tick=1: pixel_x+1; at H_TOTAL-1 pixel_x wraps to 0 and pixel_y+1.
//    pixel_y wraps from V_TOTAL-1 to 0 only on the same edge that pixel_x wraps. Both
//    wraps together raise frame_start for that one clk.
//  - hsync, vsync, video_on are registered and computed from the NEXT counter values, so
//    they change on the same edge as pixel_x/pixel_y (zero skew between coords and syncs).
//  - hsync asserted iff H_DISPLAY+H_FRONT <= pixel_x < H_DISPLAY+H_FRONT+H_SYNC (656..751).
//  - vsync asserted iff V_DISPLAY+V_FRONT <= pixel_y < V_DISPLAY+V_FRONT+V_SYNC (490..491),
//    for the whole line including blanking.
//  - Width: counters 10 bits; H_TOTAL and V_TOTAL must be <=1024 (elaboration check).
//  - Reset mid-frame: all state returns to reset values immediately; next frame begins at
//    (0,0) with no partial sync pulse held asserted.
//  - Outputs never glitch: all are flop outputs; no combinational path from inputs.
// STRUCTURE
//  - vga_timing_pkg: H_/V_ default constants, derived H_TOTAL/V_TOTAL, sync-start/end
//    localparams, SYNC_POL default; shared with Controlador_VGA and the benches.
//  - One sub-module: vga_mod_counter (parameterised mod-N counter with enable and wrap
//    output), instantiated for the divider, the horizontal and the vertical counts.
//  - Top-level contains sync/video_on decode and the output registers only.
// TESTING  (20 ns clk, DIV=2 -> 40 ns pixel)
//  1 Hold reset=0 100 ns, release -> pixel_x=pixel_y=0, hsync=vsync=1, video_on=1, p_tick
//    pulses every 40 ns, width 20 ns.
//  2 Run one line -> hsync falls when pixel_x becomes 656, low 3840 ns, rises at 752;
//    falling-edge period 32000 ns; video_on low from pixel_x=640 to 799.
//  3 Run one frame -> vsync low while pixel_y in 490..491 (64000 ns); vsync and
//    frame_start period 16,800,000 ns; frame_start coincides with pixel_x=pixel_y=0.
//  4 Wrap check -> at (799,524) the next p_tick gives (0,0); pixel_y never reaches 525,
//    pixel_x never reaches 800.
//  5 Assert reset at pixel_y=491 during vsync -> vsync=1 and counters 0 asynchronously,
//    before next clk edge; normal timing resumes after release.
//  6 DIV=1, SYNC_POL=1 build -> p_tick constant 1, line 800 clks, hsync high for 96 clks.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60Hz timing constants shared by the sync generator and its users
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int VGA_DIV       = 2;
  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam bit VGA_SYNC_POL  = 1'b0;

  localparam int VGA_H_TOTAL  = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL  = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
  localparam int VGA_HS_START = VGA_H_DISPLAY + VGA_H_FRONT;
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
  localparam int VGA_VS_START = VGA_V_DISPLAY + VGA_V_FRONT;
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

  // Counter width for a modulus; a modulus of 1 still needs one flop.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - pixel timing bundle from the sync generator to the VGA controller
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic   p_tick;
  coord_t pixel_x;
  coord_t pixel_y;
  logic   video_on;
  logic   hsync;
  logic   vsync;
  logic   frame_start;

  modport master (output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start);
  modport slave  (input  p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start);

endinterface

// File: rtl/vga_mod_counter.sv
// rtl/vga_mod_counter.sv - mod-N counter with enable; exposes its next value and a wrap strobe
module vga_mod_counter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         wrap
);

  assign wrap = en && (count == W'(N - 1));

  always_comb begin
    count_next = count;
    if (wrap)
      count_next = '0;
    else if (en)
      count_next = count + W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else
      count <= count_next;
  end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - pixel tick, h/v counters and registered sync/video_on decode
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int DIV       = VGA_DIV,
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter bit SYNC_POL  = VGA_SYNC_POL
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DW       = cnt_width(DIV);

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || DIV < 1) begin : g_param_check
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must be <= 1024 and DIV >= 1");
  end

  logic [DW-1:0] div_count, div_next;
  logic          div_wrap;
  coord_t        h_count, h_next, v_count, v_next;
  logic          h_wrap, v_wrap;
  logic          p_tick_q, video_on_q, hsync_q, vsync_q, frame_start_q;
  logic          hs_active, vs_active, video_d;
  logic          unused_div;

  vga_mod_counter #(.N(DIV), .W(DW)) u_div (
    .clk(clk), .reset(reset), .en(1'b1),
    .count(div_count), .count_next(div_next), .wrap(div_wrap)
  );

  vga_mod_counter #(.N(H_TOTAL), .W(10)) u_h (
    .clk(clk), .reset(reset), .en(p_tick_q),
    .count(h_count), .count_next(h_next), .wrap(h_wrap)
  );

  vga_mod_counter #(.N(V_TOTAL), .W(10)) u_v (
    .clk(clk), .reset(reset), .en(h_wrap),
    .count(v_count), .count_next(v_next), .wrap(v_wrap)
  );

  assign unused_div = ^{div_count, div_wrap};

  // Decode from the next counter values so syncs flip on the same edge as the coordinates.
  assign hs_active = (int'(h_next) >= HS_START) && (int'(h_next) < HS_END);
  assign vs_active = (int'(v_next) >= VS_START) && (int'(v_next) < VS_END);
  assign video_d   = (int'(h_next) < H_DISPLAY) && (int'(v_next) < V_DISPLAY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_tick_q      <= 1'b0;
      video_on_q    <= 1'b1;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      frame_start_q <= 1'b0;
    end else begin
      p_tick_q      <= (div_next == DW'(DIV - 1));
      video_on_q    <= video_d;
      hsync_q       <= hs_active ? SYNC_POL : ~SYNC_POL;
      vsync_q       <= vs_active ? SYNC_POL : ~SYNC_POL;
      frame_start_q <= h_wrap && v_wrap;
    end
  end

  assign vga.p_tick      = p_tick_q;
  assign vga.pixel_x     = h_count;
  assign vga.pixel_y     = v_count;
  assign vga.video_on    = video_on_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - bench for vga_sync_gen: full-timing DUT plus a DIV=1, positive-sync, short-frame DUT
module tb_vga_sync_gen;

  typedef struct {
    int         d;
    logic [9:0] x;
    logic [9:0] y;
    logic       pt, hs, vs, von, fs;
  } st_t;

  typedef struct {
    int div, hd, ht, hss, hse, vd, vt, vss, vse;
    bit pol;
  } cfg_t;

  typedef struct {
    int   x, y;
    logic hs, vs, von;
  } vec_t;

  logic clk = 1'b0;
  logic rst1, rst2;
  int   checks = 0;
  int   errors = 0;

  cfg_t c1 = '{div:2, hd:640, ht:800, hss:656, hse:752, vd:480, vt:525, vss:490, vse:492, pol:1'b0};
  cfg_t c2 = '{div:1, hd:640, ht:800, hss:656, hse:752, vd:4, vt:8, vss:5, vse:7, pol:1'b1};

  st_t m1, m2, e1, e2;
  st_t q1[$];
  st_t q2[$];

  always #10 clk = ~clk;

  vga_sync_gen_if i1();
  vga_sync_gen_if i2();

  vga_sync_gen u_dut1 (.clk(clk), .reset(rst1), .vga(i1));

  vga_sync_gen #(.DIV(1), .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b1)) u_dut2 (
    .clk(clk), .reset(rst2), .vga(i2)
  );

  function automatic st_t rst_state(input cfg_t c);
    st_t s;
    s.d = 0; s.x = '0; s.y = '0; s.pt = 1'b0; s.fs = 1'b0;
    s.hs = !c.pol; s.vs = !c.pol; s.von = 1'b1;
    return s;
  endfunction

  function automatic st_t step(input st_t s, input cfg_t c);
    st_t n;
    int  x, y;
    n = s;
    x = int'(s.x);
    y = int'(s.y);
    n.fs = 1'b0;
    if (s.pt) begin
      if (x == c.ht - 1) begin
        x = 0;
        if (y == c.vt - 1) begin
          y = 0;
          n.fs = 1'b1;
        end else begin
          y++;
        end
      end else begin
        x++;
      end
    end
    n.d   = (s.d == c.div - 1) ? 0 : s.d + 1;
    n.pt  = (n.d == c.div - 1);
    n.x   = 10'(x);
    n.y   = 10'(y);
    n.hs  = (x >= c.hss && x < c.hse) ? c.pol : !c.pol;
    n.vs  = (y >= c.vss && y < c.vse) ? c.pol : !c.pol;
    n.von = (x < c.hd) && (y < c.vd);
    return n;
  endfunction

  function automatic st_t obs(input int id);
    st_t s;
    s.d = 0;
    if (id == 1) begin
      s.x = i1.pixel_x; s.y = i1.pixel_y; s.pt = i1.p_tick; s.hs = i1.hsync;
      s.vs = i1.vsync; s.von = i1.video_on; s.fs = i1.frame_start;
    end else begin
      s.x = i2.pixel_x; s.y = i2.pixel_y; s.pt = i2.p_tick; s.hs = i2.hsync;
      s.vs = i2.vsync; s.von = i2.video_on; s.fs = i2.frame_start;
    end
    return s;
  endfunction

  task automatic sb_cmp(input int id, input st_t e, input st_t a);
    checks++;
    if ({a.pt, a.x, a.y, a.hs, a.vs, a.von, a.fs} !== {e.pt, e.x, e.y, e.hs, e.vs, e.von, e.fs}) begin
      errors++;
      $display("FAIL sb%0d t=%0t got pt=%b x=%0d y=%0d hs=%b vs=%b von=%b fs=%b expected pt=%b x=%0d y=%0d hs=%b vs=%b von=%b fs=%b",
               id, $time, a.pt, a.x, a.y, a.hs, a.vs, a.von, a.fs, e.pt, e.x, e.y, e.hs, e.vs, e.von, e.fs);
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected state is queued at the clock (or async reset) edge and retired mid-cycle.
  always @(posedge clk or negedge rst1) begin
    if (!rst1) begin
      q1.delete();
      q1.push_back(rst_state(c1));
      m1 <= rst_state(c1);
    end else begin
      q1.push_back(step(m1, c1));
      m1 <= step(m1, c1);
    end
  end

  always @(posedge clk or negedge rst2) begin
    if (!rst2) begin
      q2.delete();
      q2.push_back(rst_state(c2));
      m2 <= rst_state(c2);
    end else begin
      q2.push_back(step(m2, c2));
      m2 <= step(m2, c2);
    end
  end

  always @(negedge clk) begin
    if (q1.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb1 queue empty at t=%0t", $time);
    end else begin
      e1 = q1.pop_front();
      sb_cmp(1, e1, obs(1));
    end
    if (q2.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb2 queue empty at t=%0t", $time);
    end else begin
      e2 = q2.pop_front();
      sb_cmp(2, e2, obs(2));
    end
  end

  function automatic logic sig(input int w);
    case (w)
      0:       return i1.hsync;
      1:       return i1.p_tick;
      2:       return i2.frame_start;
      3:       return i2.vsync;
      4:       return i2.hsync;
      default: return 1'bx;
    endcase
  endfunction

  function automatic bit at_pos(input int id, input int x, input int y);
    if (id == 1)
      return (x < 0 || i1.pixel_x == 10'(x)) && i1.pixel_y == 10'(y);
    return (x < 0 || i2.pixel_x == 10'(x)) && i2.pixel_y == 10'(y);
  endfunction

  task automatic wait_lvl(input int w, input logic lvl, output time t);
    int n;
    n = 0;
    while (sig(w) !== lvl && n < 20000) begin
      @(negedge clk);
      n++;
    end
    t = $time;
    checks++;
    if (sig(w) !== lvl) begin
      errors++;
      $display("FAIL wait sig%0d: got %b expected %b within 20000 cycles", w, sig(w), lvl);
    end
  endtask

  task automatic wait_pos(input int id, input int x, input int y);
    int n;
    n = 0;
    while (!at_pos(id, x, y) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!at_pos(id, x, y)) begin
      errors++;
      $display("FAIL wait_pos dut%0d: got no visit expected (%0d,%0d) within 20000 cycles", id, x, y);
    end
  endtask

  initial begin
    vec_t vecs[9];
    time  t0, t1, t2, t3;
    int   bad;

    vecs[0] = '{639, 0, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{640, 0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{655, 0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{656, 0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{751, 0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{752, 0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{799, 0, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{0,   1, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{656, 1, 1'b0, 1'b1, 1'b0};

    rst1 = 1'b0;
    rst2 = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst d1 pixel_x", i1.pixel_x, 0);
    chk("rst d1 pixel_y", i1.pixel_y, 0);
    chk("rst d1 hsync", i1.hsync, 1);
    chk("rst d1 vsync", i1.vsync, 1);
    chk("rst d1 video_on", i1.video_on, 1);
    chk("rst d1 p_tick", i1.p_tick, 0);
    chk("rst d1 frame_start", i1.frame_start, 0);
    chk("rst d2 hsync", i2.hsync, 0);
    chk("rst d2 vsync", i2.vsync, 0);
    rst1 = 1'b1;
    rst2 = 1'b1;

    wait_lvl(1, 1'b0, t0);
    wait_lvl(1, 1'b1, t0);
    wait_lvl(1, 1'b0, t1);
    wait_lvl(1, 1'b1, t2);
    chk("d1 p_tick width ns", longint'(t1 - t0), 20);
    chk("d1 p_tick period ns", longint'(t2 - t0), 40);

    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (i2.p_tick !== 1'b1) bad++;
    end
    chk("d2 p_tick low cycles", bad, 0);

    for (int i = 0; i < 9; i++) begin
      wait_pos(1, vecs[i].x, vecs[i].y);
      chk($sformatf("vec%0d hsync", i), i1.hsync, vecs[i].hs);
      chk($sformatf("vec%0d vsync", i), i1.vsync, vecs[i].vs);
      chk($sformatf("vec%0d video_on", i), i1.video_on, vecs[i].von);
    end

    wait_lvl(0, 1'b1, t0);
    wait_lvl(0, 1'b0, t1);
    wait_lvl(0, 1'b1, t2);
    wait_lvl(0, 1'b0, t3);
    chk("d1 hsync low ns", longint'(t2 - t1), 3840);
    chk("d1 hsync period ns", longint'(t3 - t1), 32000);

    wait_lvl(4, 1'b0, t0);
    wait_lvl(4, 1'b1, t0);
    wait_lvl(4, 1'b0, t1);
    wait_lvl(4, 1'b1, t2);
    chk("d2 hsync high ns", longint'(t1 - t0), 1920);
    chk("d2 line period ns", longint'(t2 - t0), 16000);

    wait_pos(2, 799, 7);
    chk("d2 frame_start before wrap", i2.frame_start, 0);
    @(negedge clk);
    chk("d2 wrap pixel_x", i2.pixel_x, 0);
    chk("d2 wrap pixel_y", i2.pixel_y, 0);
    chk("d2 wrap frame_start", i2.frame_start, 1);
    t0 = $time;
    @(negedge clk);
    chk("d2 frame_start one clk", i2.frame_start, 0);
    wait_lvl(2, 1'b1, t1);
    chk("d2 frame period ns", longint'(t1 - t0), 128000);

    wait_lvl(3, 1'b1, t0);
    wait_lvl(3, 1'b0, t1);
    chk("d2 vsync active ns", longint'(t1 - t0), 32000);

    wait_pos(2, -1, 6);
    chk("d2 vsync before reset", i2.vsync, 1);
    #5;
    rst2 = 1'b0;
    #1;
    chk("async rst d2 vsync", i2.vsync, 0);
    chk("async rst d2 hsync", i2.hsync, 0);
    chk("async rst d2 pixel_x", i2.pixel_x, 0);
    chk("async rst d2 pixel_y", i2.pixel_y, 0);
    chk("async rst d2 p_tick", i2.p_tick, 0);
    chk("async rst d2 video_on", i2.video_on, 1);
    @(negedge clk);
    @(negedge clk);
    rst2 = 1'b1;
    t0 = $time;
    wait_lvl(3, 1'b1, t1);
    chk("d2 vsync after release ns", longint'(t1 - t0), 80020);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
